// File: rtl/thread_registers_pkg.sv
// Shared core definitions: phase encodings, write-source select and
// special register indices used by decoder, ALU and register files.
package thread_registers_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    MUX_ARITH  = 2'b00,
    MUX_MEMORY = 2'b01,
    MUX_CONST  = 2'b10,
    MUX_RSVD   = 2'b11
  } reg_mux_e;

  localparam int NUM_GPR  = 13;
  localparam int NUM_VREG = 8;

  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;

  function automatic logic is_special(input logic [3:0] a);
    return a >= REG_BLOCK_IDX;
  endfunction

endpackage

// File: rtl/thread_registers_vector_bank.sv
// Eight-entry vector register file: one write port and two
// registered read ports that only update when i_re is high.
module vector_bank
  import thread_registers_pkg::*;
#(
  parameter int Vector_Size = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [2:0]               i_wa,
  input  logic [8*Vector_Size-1:0] i_wd,
  input  logic                     i_re,
  input  logic [2:0]               i_ra_s,
  input  logic [2:0]               i_ra_t,
  output logic [8*Vector_Size-1:0] o_rd_s,
  output logic [8*Vector_Size-1:0] o_rd_t
);

  logic [8*Vector_Size-1:0] r_mem [NUM_VREG];
  logic [8*Vector_Size-1:0] r_rd_s;
  logic [8*Vector_Size-1:0] r_rd_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VREG; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_s <= '0;
      r_rd_t <= '0;
    end else if (i_re) begin
      r_rd_s <= r_mem[i_ra_s];
      r_rd_t <= r_mem[i_ra_t];
    end
  end

  assign o_rd_s = r_rd_s;
  assign o_rd_t = r_rd_t;

endmodule

// File: rtl/thread_registers.sv
// Per-thread scalar and vector register files with read-in-REQUEST,
// write-in-UPDATE timing and read-only block/thread id registers.
module thread_registers
  import thread_registers_pkg::*;
#(
  parameter int Threads_Per_Block = 4,
  parameter int Thread_Id         = 0,
  parameter int Vector_Size       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               block_id,
  input  logic [2:0]               core_state,
  input  logic [3:0]               decoded_rd_address,
  input  logic [3:0]               decoded_rs_address,
  input  logic [3:0]               decoded_rt_address,
  input  logic                     decoded_reg_write_enable,
  input  logic [1:0]               decoded_reg_input_mux,
  input  logic [7:0]               decoded_immediate,
  input  logic                     decoded_alu_vector_mux,
  input  logic [7:0]               alu_out,
  input  logic [8*Vector_Size-1:0] v_alu_out,
  input  logic [7:0]               lsu_out,
  output logic [7:0]               rs,
  output logic [7:0]               rt,
  output logic [8*Vector_Size-1:0] v_rs,
  output logic [8*Vector_Size-1:0] v_rt
);

  localparam logic [7:0] BLOCK_DIM = 8'(Threads_Per_Block);
  localparam logic [7:0] THREAD_ID = 8'(Thread_Id);

  logic [7:0] r_gpr [NUM_GPR];
  logic [7:0] r_block_idx;
  logic [7:0] r_rs;
  logic [7:0] r_rt;

  logic                     w_req;
  logic                     w_upd;
  logic                     w_s_we;
  logic [7:0]               w_s_wd;
  logic                     w_v_we;
  logic [8*Vector_Size-1:0] w_v_wd;
  logic [7:0]               w_rs_val;
  logic [7:0]               w_rt_val;

  assign w_req = enable && (core_state == CORE_REQUEST);
  assign w_upd = enable && (core_state == CORE_UPDATE)
              && decoded_reg_write_enable;

  function automatic logic [7:0] f_read(input logic [3:0] a);
    logic [7:0] v;
    v = '0;
    unique case (1'b1)
      (a == REG_BLOCK_IDX):  v = r_block_idx;
      (a == REG_BLOCK_DIM):  v = BLOCK_DIM;
      (a == REG_THREAD_IDX): v = THREAD_ID;
      (!is_special(a)):      v = r_gpr[a];
    endcase
    return v;
  endfunction

  always_comb begin
    w_rs_val = f_read(decoded_rs_address);
    w_rt_val = f_read(decoded_rt_address);
  end

  // Special registers are read-only; such writes vanish here
  always_comb begin
    w_s_we = 1'b0;
    w_s_wd = alu_out;
    if (w_upd && !decoded_alu_vector_mux
        && !is_special(decoded_rd_address)) begin
      case (decoded_reg_input_mux)
        MUX_ARITH:  begin w_s_we = 1'b1; w_s_wd = alu_out; end
        MUX_MEMORY: begin w_s_we = 1'b1; w_s_wd = lsu_out; end
        MUX_CONST:  begin
          w_s_we = 1'b1;
          w_s_wd = decoded_immediate;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_v_we = 1'b0;
    w_v_wd = v_alu_out;
    if (w_upd && decoded_alu_vector_mux) begin
      case (decoded_reg_input_mux)
        MUX_ARITH: begin w_v_we = 1'b1; w_v_wd = v_alu_out; end
        MUX_CONST: begin
          w_v_we = 1'b1;
          w_v_wd = {Vector_Size{decoded_immediate}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++)
        r_gpr[i] <= '0;
      r_block_idx <= '0;
    end else if (enable) begin
      r_block_idx <= block_id;
      if (w_s_we)
        r_gpr[decoded_rd_address] <= w_s_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs <= '0;
      r_rt <= '0;
    end else if (w_req) begin
      r_rs <= w_rs_val;
      r_rt <= w_rt_val;
    end
  end

  vector_bank #(
    .Vector_Size (Vector_Size)
  ) u_vbank (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_v_we),
    .i_wa   (decoded_rd_address[2:0]),
    .i_wd   (w_v_wd),
    .i_re   (w_req),
    .i_ra_s (decoded_rs_address[2:0]),
    .i_ra_t (decoded_rt_address[2:0]),
    .o_rd_s (v_rs),
    .o_rd_t (v_rt)
  );

  assign rs = r_rs;
  assign rt = r_rt;

endmodule

// File: tb/tb_thread_registers.sv
// Directed bench for thread_registers with a behavioural register
// model checked every cycle plus hand-computed literal expectations.
module tb_thread_registers;

  localparam int TPB = 4;
  localparam int TID = 2;
  localparam int VS  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    block_id = '0;
  logic [2:0]    core_state = '0;
  logic [3:0]    rd_a = '0;
  logic [3:0]    rs_a = '0;
  logic [3:0]    rt_a = '0;
  logic          we = 1'b0;
  logic [1:0]    mux = '0;
  logic [7:0]    imm = '0;
  logic          vm = 1'b0;
  logic [7:0]    alu_out = '0;
  logic [8*VS-1:0] v_alu_out = '0;
  logic [7:0]    lsu_out = '0;
  logic [7:0]    rs;
  logic [7:0]    rt;
  logic [8*VS-1:0] v_rs;
  logic [8*VS-1:0] v_rt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  thread_registers #(
    .Threads_Per_Block (TPB),
    .Thread_Id         (TID),
    .Vector_Size       (VS)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .block_id                 (block_id),
    .core_state               (core_state),
    .decoded_rd_address       (rd_a),
    .decoded_rs_address       (rs_a),
    .decoded_rt_address       (rt_a),
    .decoded_reg_write_enable (we),
    .decoded_reg_input_mux    (mux),
    .decoded_immediate        (imm),
    .decoded_alu_vector_mux   (vm),
    .alu_out                  (alu_out),
    .v_alu_out                (v_alu_out),
    .lsu_out                  (lsu_out),
    .rs                       (rs),
    .rt                       (rt),
    .v_rs                     (v_rs),
    .v_rt                     (v_rt)
  );

  // Behavioural model: plain arrays, updated from the rules directly
  logic [7:0]      m_r [13];
  logic [7:0]      m_bidx;
  logic [7:0]      m_v [8][VS];
  logic [7:0]      e_rs;
  logic [7:0]      e_rt;
  logic [8*VS-1:0] e_vrs;
  logic [8*VS-1:0] e_vrt;
  bit              live = 1'b0;

  function automatic logic [7:0] sval(input logic [3:0] a);
    if (a == 4'd13) return m_bidx;
    if (a == 4'd14) return 8'(TPB);
    if (a == 4'd15) return 8'(TID);
    return m_r[a];
  endfunction

  function automatic logic [8*VS-1:0] vval(input logic [2:0] a);
    logic [8*VS-1:0] v;
    for (int i = 0; i < VS; i++) v[8*i +: 8] = m_v[a][i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) m_r[i] <= '0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < VS; j++) m_v[i][j] <= '0;
      m_bidx <= '0;
      e_rs <= '0;
      e_rt <= '0;
      e_vrs <= '0;
      e_vrt <= '0;
      live <= 1'b1;
    end else if (enable) begin
      m_bidx <= block_id;
      if (core_state == 3'b011) begin
        e_rs  <= sval(rs_a);
        e_rt  <= sval(rt_a);
        e_vrs <= vval(rs_a[2:0]);
        e_vrt <= vval(rt_a[2:0]);
      end
      if (core_state == 3'b110 && we) begin
        if (!vm) begin
          if (rd_a < 4'd13) begin
            if (mux == 2'd0) m_r[rd_a] <= alu_out;
            if (mux == 2'd1) m_r[rd_a] <= lsu_out;
            if (mux == 2'd2) m_r[rd_a] <= imm;
          end
        end else begin
          for (int i = 0; i < VS; i++) begin
            if (mux == 2'd0) m_v[rd_a[2:0]][i] <= v_alu_out[8*i +: 8];
            if (mux == 2'd2) m_v[rd_a[2:0]][i] <= imm;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("model rs", 64'(rs), 64'(e_rs));
      chk("model rt", 64'(rt), 64'(e_rt));
      chk("model v_rs", 64'(v_rs), 64'(e_vrs));
      chk("model v_rt", 64'(v_rt), 64'(e_vrt));
    end
  end

  task automatic step(input logic [2:0] st, input logic en,
                      input logic [3:0] s, input logic [3:0] t,
                      input logic [3:0] d, input logic w,
                      input logic [1:0] m, input logic v,
                      input logic [7:0] im, input logic [7:0] a,
                      input logic [31:0] va, input logic [7:0] l);
    core_state = st;
    enable = en;
    rs_a = s;
    rt_a = t;
    rd_a = d;
    we = w;
    mux = m;
    vm = v;
    imm = im;
    alu_out = a;
    v_alu_out = va;
    lsu_out = l;
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] s, input logic [3:0] t);
    step(3'b011, 1'b1, s, t, 4'd0, 1'b0, 2'd0, 1'b0,
         8'h00, 8'h00, 32'h0, 8'h00);
  endtask

  task automatic upd(input logic en, input logic v,
                     input logic [3:0] d, input logic [1:0] m,
                     input logic [7:0] im, input logic [7:0] a,
                     input logic [31:0] va, input logic [7:0] l);
    step(3'b110, en, 4'd0, 4'd0, d, 1'b1, m, v, im, a, va, l);
  endtask

  initial begin
    block_id = 8'h09;
    @(negedge clk);
    step(3'b000, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0,
         8'h00, 8'h00, 32'h0, 8'h00);
    chk("reset rs", 64'(rs), 64'h0);
    chk("reset rt", 64'(rt), 64'h0);
    chk("reset v_rs", 64'(v_rs), 64'h0);
    chk("reset v_rt", 64'(v_rt), 64'h0);
    reset = 1'b0;

    req(4'd15, 4'd14);
    chk("thread_idx", 64'(rs), 64'h02);
    chk("block_dim", 64'(rt), 64'h04);
    chk("init v_rs", 64'(v_rs), 64'h0);
    chk("init v_rt", 64'(v_rt), 64'h0);

    upd(1'b1, 1'b0, 4'd3, 2'd0, 8'h00, 8'h5A, 32'h0, 8'h00);
    req(4'd3, 4'd3);
    chk("R3 alu", 64'(rs), 64'h5A);

    upd(1'b1, 1'b0, 4'd13, 2'd2, 8'h77, 8'h00, 32'h0, 8'h00);
    req(4'd13, 4'd0);
    chk("R13 ro", 64'(rs), 64'h09);

    upd(1'b1, 1'b1, 4'd9, 2'd2, 8'h11, 8'h00, 32'h0, 8'h00);
    req(4'd1, 4'd1);
    chk("V1 bcast", 64'(v_rs), 64'h11111111);
    upd(1'b1, 1'b1, 4'd1, 2'd1, 8'h00, 8'h00, 32'hDEADBEEF, 8'h00);
    req(4'd1, 4'd1);
    chk("V1 mux01", 64'(v_rs), 64'h11111111);

    upd(1'b1, 1'b1, 4'd2, 2'd0, 8'h00, 8'h00, 32'h04030201, 8'h00);
    req(4'd0, 4'd2);
    chk("V2 alu", 64'(v_rt), 64'h04030201);
    chk("R2 zero", 64'(rt), 64'h00);

    upd(1'b1, 1'b0, 4'd8, 2'd1, 8'h00, 8'h00, 32'h0, 8'hC3);
    req(4'd8, 4'd15);
    chk("R8 lsu", 64'(rs), 64'hC3);
    upd(1'b1, 1'b0, 4'd6, 2'd3, 8'h00, 8'h44, 32'h0, 8'h00);
    req(4'd6, 4'd0);
    chk("R6 mux11", 64'(rs), 64'h00);
    upd(1'b1, 1'b0, 4'd14, 2'd0, 8'h00, 8'h55, 32'h0, 8'h00);
    req(4'd14, 4'd13);
    chk("R14 ro", 64'(rs), 64'h04);

    step(3'b011, 1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 2'd0, 1'b0,
         8'h00, 8'h66, 32'h0, 8'h00);
    req(4'd7, 4'd0);
    chk("no wr in req", 64'(rs), 64'h00);

    upd(1'b0, 1'b0, 4'd4, 2'd0, 8'h00, 8'hFF, 32'h0, 8'h00);
    req(4'd4, 4'd3);
    chk("R4 en0", 64'(rs), 64'h00);
    chk("R3 keep", 64'(rt), 64'h5A);

    block_id = 8'h33;
    step(3'b011, 1'b0, 4'd3, 4'd8, 4'd0, 1'b0, 2'd0, 1'b0,
         8'h00, 8'h00, 32'h0, 8'h00);
    chk("hold rs", 64'(rs), 64'h00);
    chk("hold rt", 64'(rt), 64'h5A);
    req(4'd13, 4'd13);
    chk("R13 frozen", 64'(rs), 64'h09);
    req(4'd13, 4'd0);
    chk("R13 reload", 64'(rs), 64'h33);

    reset = 1'b1;
    upd(1'b1, 1'b0, 4'd5, 2'd0, 8'h00, 8'hAB, 32'h0, 8'h00);
    reset = 1'b0;
    chk("rst rs", 64'(rs), 64'h00);
    req(4'd5, 4'd3);
    chk("R5 rst", 64'(rs), 64'h00);
    chk("R3 rst", 64'(rt), 64'h00);
    req(4'd15, 4'd2);
    chk("tid rst", 64'(rs), 64'h02);
    chk("V2 rst", 64'(v_rt), 64'h0);
    step(3'b000, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0,
         8'h00, 8'h00, 32'h0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_registers.md
THREAD_REGISTERS -- requirements
Module: thread_registers

Interface
REQ-001 Parameters SHALL be: Threads_Per_Block, default 4, threads per block; Thread_Id, default 0, this thread's index; Vector_Size, default 4, lanes per vector register.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  thread active; low freezes all state.
- block_id  in  8  current block index.
- core_state  in  3  core phase (011 REQUEST, 110 UPDATE).
- decoded_rd_address  in  4  destination register.
- decoded_rs_address  in  4  source register s.
- decoded_rt_address  in  4  source register t.
- decoded_reg_write_enable  in  1  write requested.
- decoded_reg_input_mux  in  2  write source (00 ARITHMETIC, 01 MEMORY, 10 CONSTANT, 11 reserved).
- decoded_immediate  in  8  constant operand.
- decoded_alu_vector_mux  in  1  vector instruction.
- alu_out  in  8  scalar ALU result.
- v_alu_out  in  8*Vector_Size  vector ALU result.
- lsu_out  in  8  load data.
- rs  out  8  scalar operand s.
- rt  out  8  scalar operand t.
- v_rs  out  8*Vector_Size  vector operand s.
- v_rt  out  8*Vector_Size  vector operand t.

Function
REQ-003 Scalar file SHALL hold 16 x 8-bit registers: R0-R12 general, R13 block_idx, R14 block_dim, R15 thread_idx.
REQ-004 Vector file SHALL hold 8 registers V0-V7, each Vector_Size 8-bit lanes, lane i at bits [8i+7:8i], addressed by address bits [2:0]; bit 3 ignored.
REQ-005 R13 SHALL load block_id every cycle enable is high; R14 SHALL read Threads_Per_Block; R15 SHALL read Thread_Id.
REQ-006 When enable and core_state==011, rs/rt SHALL register R[rs_addr]/R[rt_addr] and v_rs/v_rt SHALL register V[rs_addr[2:0]]/V[rt_addr[2:0]] on that edge; latency one cycle; outputs hold otherwise.
REQ-007 Scalar write SHALL occur when enable, core_state==110, write_enable, vector_mux==0 and rd<13: mux 00 writes alu_out, 01 lsu_out, 10 decoded_immediate, 11 no write.
REQ-008 Writes addressing R13-R15 SHALL be silently discarded.
REQ-009 Vector write SHALL occur when enable, core_state==110, write_enable, vector_mux==1: mux 00 writes v_alu_out to V[rd[2:0]]; 10 broadcasts decoded_immediate to all lanes; 01 and 11 no write.
REQ-010 No write SHALL occur in any state other than 110; no read update in any state other than 011.
REQ-011 No same-cycle bypass SHALL exist; REQUEST and UPDATE occupy distinct cycles so reads always see committed state.
REQ-012 enable low SHALL hold all registers and outputs, including R13.

Reset
REQ-013 On reset, R0-R13, V0-V7, rs, rt, v_rs, v_rt SHALL clear to 0; R14/R15 SHALL read their parameter constants.
REQ-014 Reset SHALL override enable and any write or read in the same cycle; reset mid-UPDATE discards the write.

Structure
REQ-015 Core state encodings, reg_input_mux encodings, and special-register indices (13,14,15) SHALL live in a shared core package used by decoder, ALU and this block.
REQ-016 One sub-module, vector_bank, SHALL implement the 8-entry vector file with one write and two registered read ports.

Verification
REQ-017 Reset, then REQUEST rs=15 rt=14, Thread_Id=2 -> rs=2, rt=4, v_rs=v_rt=0.
REQ-018 UPDATE rd=3 mux=00 alu_out=0x5A, then REQUEST rs=3 -> rs=0x5A one cycle after REQUEST edge.
REQ-019 UPDATE rd=13 mux=10 imm=0x77, block_id=0x09 -> REQUEST rs=13 yields 0x09.
REQ-020 Vector UPDATE rd=9 mux=10 imm=0x11 -> REQUEST rs=1 gives v_rs=0x11111111; mux=01 write leaves V1 unchanged.
REQ-021 enable=0 during UPDATE rd=4 alu_out=0xFF -> R4 stays 0; reset asserted in UPDATE cycle rd=5 -> R5=0.
